// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential Booth multiplier, signed or unsigned operands.
// RADIX4=0 retires one multiplier bit per cycle, RADIX4=1 retires two bits
// per cycle using modified Booth recoding. Handshake is start/busy/done.
// Operands are widened by at least one bit so that unsigned values recode
// correctly. The product register holds its value until the next done.
module booth_mult_seq #(
    parameter int WIDTH  = 6,
    parameter int RADIX4 = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // The extended width is rounded up to even in radix-4 so that whole
    // recoding triplets are consumed.
    localparam int E    = (RADIX4 != 0) ? (((WIDTH + 2) / 2) * 2) : (WIDTH + 1);
    localparam int ITER = (RADIX4 != 0) ? (E / 2) : E;
    localparam int SH   = (RADIX4 != 0) ? 2 : 1;
    localparam int AW   = E + 2;
    localparam int XW   = AW + E + 1;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [E-1:0]       mq_q, mq_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [E-1:0]       m_q, m_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [E-1:0]  a_ext, b_ext;
    logic [AW-1:0] m_ext, addend, sum;
    logic [XW-1:0] shift_in, shift_out;

    // Widen the incoming operands: sign-extend for two's complement, zero-extend otherwise.
    always_comb begin
        a_ext = tc ? {{(E-WIDTH){a[WIDTH-1]}}, a} : {{(E-WIDTH){1'b0}}, a};
        b_ext = tc ? {{(E-WIDTH){b[WIDTH-1]}}, b} : {{(E-WIDTH){1'b0}}, b};
    end

    // One Booth iteration: recode, add the selected multiple of M, then arithmetic shift.
    always_comb begin
        m_ext  = {{2{m_q[E-1]}}, m_q};
        addend = '0;
        if (RADIX4 != 0) begin
            case ({mq_q[1:0], q1_q})
                3'b001, 3'b010: addend = m_ext;
                3'b011:         addend = {m_ext[AW-2:0], 1'b0};
                3'b100:         addend = -{m_ext[AW-2:0], 1'b0};
                3'b101, 3'b110: addend = -m_ext;
                default:        addend = '0;
            endcase
        end else begin
            case ({mq_q[0], q1_q})
                2'b01:   addend = m_ext;
                2'b10:   addend = -m_ext;
                default: addend = '0;
            endcase
        end
        sum       = acc_q + addend;
        shift_in  = {sum, mq_q, q1_q};
        shift_out = $unsigned($signed(shift_in) >>> SH);
    end

    // Control: accept start in IDLE or DONE, run ITER iterations, and capture the product on DONE entry.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    mq_d    = a_ext;
                    m_d     = b_ext;
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = shift_out[XW-1 -: AW];
                mq_d  = shift_out[E:1];
                q1_d  = shift_out[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    prod_d  = shift_out[2*WIDTH:1];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; an asserted reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mq_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            m_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: eight multiplier configurations (WIDTH 6,4,8,16 in both
// radices) share one clock and reset. Drivers push expected products and done
// cycles into per-configuration queues; a monitor pops and compares on done.
module tb_booth_mult_seq;

    localparam int NCFG = 8;
    localparam int NOPS = 2000;

    logic        clk;
    logic        rst_n;
    logic        start  [NCFG];
    logic        tc_s   [NCFG];
    logic [15:0] a_s    [NCFG];
    logic [15:0] b_s    [NCFG];
    logic        busy_w [NCFG];
    logic        done_w [NCFG];
    logic [31:0] prod_w [NCFG];

    logic [31:0] exp_prod [NCFG][$];
    int          exp_cyc  [NCFG][$];
    logic [31:0] held     [NCFG];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int sweeps_done = 0;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W = (g < 2) ? 6 : (g < 4) ? 4 : (g < 6) ? 8 : 16;
        logic [2*W-1:0] p;
        booth_mult_seq #(.WIDTH(W), .RADIX4(g % 2)) u_dut (
            .clk     (clk),
            .rst     (rst_n),
            .start   (start[g]),
            .tc      (tc_s[g]),
            .a       (a_s[g][W-1:0]),
            .b       (b_s[g][W-1:0]),
            .busy    (busy_w[g]),
            .done    (done_w[g]),
            .product (p)
        );
        assign prod_w[g] = 32'(p);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_width(input int k);
        return (k < 2) ? 6 : (k < 4) ? 4 : (k < 6) ? 8 : 16;
    endfunction

    function automatic int cfg_iter(input int k);
        int e;
        e = cfg_width(k) + 1;
        if ((k % 2) == 1) begin
            if ((e % 2) == 1) e = e + 1;
            return e / 2;
        end
        return e;
    endfunction

    // Reference: plain integer multiply of the interpreted operands, reduced modulo 2^(2W).
    function automatic logic [31:0] ref_mult(input int w, input bit tcv,
                                             input logic [15:0] av, input logic [15:0] bv);
        longint lim, ua, ub, pr;
        lim = longint'(1) << w;
        ua  = longint'({48'd0, av}) % lim;
        ub  = longint'({48'd0, bv}) % lim;
        if (tcv) begin
            if (ua >= lim / 2) ua = ua - lim;
            if (ub >= lim / 2) ub = ub - lim;
        end
        pr = (ua * ub) & ((longint'(1) << (2 * w)) - 1);
        return 32'(pr);
    endfunction

    function automatic logic [15:0] pick(input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        case ($urandom_range(0, 5))
            0:       return 16'd0;
            1:       return 16'(mask);
            2:       return 16'(32'd1 << (w - 1));
            3:       return 16'((32'd1 << (w - 1)) - 32'd1);
            default: return 16'($urandom & mask);
        endcase
    endfunction

    task automatic check_output(input int k, input string name,
                                input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("[TB] FAIL cfg%0d %s: got 0x%0h required 0x%0h", k, name, act, expv);
        end
    endtask

    // Issue one operation at a negedge and wait for its done cycle.
    // mode 0: start dropped after accept; 1: random start pulses and operand
    // noise while running; 2: start held high with operand noise.
    task automatic apply_stimulus(input int k, input bit tcv, input logic [15:0] av,
                                  input logic [15:0] bv, input int mode,
                                  output logic [31:0] p, output int nbusy, output int lat);
        int it;
        it = cfg_iter(k);
        tc_s[k]  = tcv;
        a_s[k]   = av;
        b_s[k]   = bv;
        start[k] = 1'b1;
        exp_prod[k].push_back(ref_mult(cfg_width(k), tcv, av, bv));
        exp_cyc[k].push_back(cyc + 1 + it);
        nbusy = 0;
        @(negedge clk);
        lat = 1;
        while (!done_w[k] && lat < it + 4) begin
            if (busy_w[k]) nbusy = nbusy + 1;
            if (mode == 0) begin
                start[k] = 1'b0;
            end else begin
                start[k] = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                a_s[k]   = 16'($urandom);
                b_s[k]   = 16'($urandom);
                tc_s[k]  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat = lat + 1;
        end
        check_output(k, "done_seen", {31'd0, done_w[k]}, 32'd1);
        p = prod_w[k];
    endtask

    // Randomised back-to-back and gapped operations on one configuration.
    task automatic sweep(input int k);
        logic [31:0] p;
        int nb, lat;
        logic [15:0] av, bv;
        for (int i = 0; i < NOPS; i++) begin
            av = pick(cfg_width(k));
            bv = pick(cfg_width(k));
            apply_stimulus(k, (i % 2) == 1, av, bv, 1, p, nb, lat);
            if ($urandom_range(0, 2) == 0) begin
                start[k] = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        start[k] = 1'b0;
        sweeps_done = sweeps_done + 1;
    endtask

    // Monitor: pop and compare on every done, check latency, exclusivity and product hold.
    initial begin
        for (int k = 0; k < NCFG; k++) held[k] = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NCFG; k++) begin
                if (!rst_n) begin
                    held[k] = '0;
                end else begin
                    check_output(k, "busy_done_excl", {31'd0, busy_w[k] & done_w[k]}, 32'd0);
                    if (done_w[k]) begin
                        if (exp_prod[k].size() == 0) begin
                            checks = checks + 1;
                            errors = errors + 1;
                            $display("[TB] FAIL cfg%0d unexpected_done: got done=1 required no pending op", k);
                        end else begin
                            held[k] = exp_prod[k].pop_front();
                            check_output(k, "product", prod_w[k], held[k]);
                            check_output(k, "done_cycle", 32'(cyc), 32'(exp_cyc[k].pop_front()));
                        end
                    end else begin
                        check_output(k, "product_hold", prod_w[k], held[k]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] p;
        int nb, lat, dcount;
        rst_n = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
            start[k] = 1'b0;
            tc_s[k]  = 1'b0;
            a_s[k]   = '0;
            b_s[k]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NCFG; k++) begin
            check_output(k, "reset_busy", {31'd0, busy_w[k]}, 32'd0);
            check_output(k, "reset_done", {31'd0, done_w[k]}, 32'd0);
            check_output(k, "reset_product", prod_w[k], 32'd0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed: corner products, latency and busy length");
        apply_stimulus(0, 1'b1, 16'h20, 16'h20, 0, p, nb, lat);
        check_output(0, "neg32_x_neg32", p, 32'h400);
        check_output(0, "r2_latency", 32'(lat), 32'd8);
        check_output(0, "r2_busy_cycles", 32'(nb), 32'd7);
        apply_stimulus(1, 1'b1, 16'h1F, 16'h20, 0, p, nb, lat);
        check_output(1, "31_x_neg32", p, 32'hC20);
        check_output(1, "r4_latency", 32'(lat), 32'd5);
        check_output(1, "r4_busy_cycles", 32'(nb), 32'd4);
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(k, 1'b0, 16'h3F, 16'h3F, 0, p, nb, lat);
            check_output(k, "u63_x_u63", p, 32'hF81);
            apply_stimulus(k, 1'b0, 16'h00, 16'h3F, 0, p, nb, lat);
            check_output(k, "u0_x_u63", p, 32'h000);
        end

        $display("[TB] directed: start held across two back-to-back ops");
        apply_stimulus(0, 1'b1, 16'h05, 16'h3D, 2, p, nb, lat);
        check_output(0, "held_op1", p, 32'hFF1);
        apply_stimulus(0, 1'b1, 16'h3F, 16'h3F, 2, p, nb, lat);
        start[0] = 1'b0;
        check_output(0, "held_op2", p, 32'h001);
        check_output(0, "held_op2_latency", 32'(lat), 32'd8);
        apply_stimulus(1, 1'b1, 16'h2A, 16'h15, 1, p, nb, lat);
        start[1] = 1'b0;
        check_output(1, "noisy_run", p, 32'hE32);

        $display("[TB] directed: asynchronous reset during iteration 3");
        tc_s[0]  = 1'b1;
        a_s[0]   = 16'h39;
        b_s[0]   = 16'h09;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output(0, "async_rst_busy", {31'd0, busy_w[0]}, 32'd0);
        check_output(0, "async_rst_done", {31'd0, done_w[0]}, 32'd0);
        check_output(0, "async_rst_product", prod_w[0], 32'd0);
        check_output(1, "async_rst_product", prod_w[1], 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_w[0]) dcount = dcount + 1;
        end
        check_output(0, "no_done_after_abort", 32'(dcount), 32'd0);
        apply_stimulus(0, 1'b1, 16'h39, 16'h09, 0, p, nb, lat);
        check_output(0, "post_reset_op", p, 32'hFC1);

        $display("[TB] random sweep: %0d ops per configuration", NOPS);
        for (int g = 0; g < NCFG; g++) begin
            automatic int k = g;
            fork
                sweep(k);
            join_none
        end
        wait (sweeps_done == NCFG);
        repeat (3) @(negedge clk);
        for (int k = 0; k < NCFG; k++)
            check_output(k, "pending_ops", 32'(exp_prod[k].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential Booth multiplier, successor to the fixed 6-bit radix-2 multiplier in the arithmetic lab blocks. It multiplies two WIDTH-bit operands as either two's-complement or unsigned values. RADIX4 selects radix-2 or radix-4 (modified Booth) recoding. It uses a start/busy/done handshake and replaces free-running counting after a load. It sits between the operand registers/switch front-end and the product display or datapath consumer, all in the single system clock domain.

## Interface
- WIDTH, 6: operand width in bits; legal range 2..32.
- RADIX4, 0: 0 selects radix-2 Booth (1 multiplier bit per cycle); 1 selects radix-4 Booth (2 bits per cycle).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-low.
- start  input  1  request; accepted only in IDLE or DONE.
- tc  input  1  sampled with start; 1 treats operands as two's complement, 0 as unsigned.
- a  input  WIDTH  multiplier, sampled on accepted start.
- b  input  WIDTH  multiplicand, sampled on accepted start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when product updates.
- product  output  2*WIDTH  result register; holds until the next done.

## Operation
- Internal extended width:
  - E = WIDTH+1 when RADIX4=0.
  - E = WIDTH+1 rounded up to even when RADIX4=1.
  - Operands are sign-extended (tc=1) or zero-extended (tc=0) to E bits.
  - This extension makes unsigned operands correct under Booth recoding.
- Iteration count: ITER = E for radix-2, E/2 for radix-4.
- Datapath: accumulator A of E+2 bits, multiplier shift register Q of E bits, guard bit q_1, iteration counter.
- States are IDLE, RUN and DONE.
  - IDLE -> RUN on start=1. Same edge: latch extended a into Q and extended b as M; clear A and q_1; clear the counter.
  - RUN: one iteration per cycle. After the ITER-th iteration, go to DONE.
  - DONE: product <= low 2*WIDTH bits of {A,Q}; done=1 for exactly this cycle. Next state is RUN if start=1, else IDLE.
- Radix-2 recoding on {Q[0],q_1}:
  - 01 adds M; 10 subtracts M; 00 and 11 do nothing.
  - Then arithmetic-shift {A,Q,q_1} right by 1.
- Radix-4 recoding on {Q[1],Q[0],q_1}:
  - 000 and 111 give 0; 001 and 010 give +M; 011 gives +2M.
  - 100 gives -2M; 101 and 110 give -M.
  - Then arithmetic-shift {A,Q,q_1} right by 2.
- All additions are modulo 2^(E+2); the shift replicates A's MSB.
- The true product always fits in 2*WIDTH bits, so truncation is exact in both modes.
- Operands are latched: a, b and tc changes during RUN have no effect.

## Timing
- Reset (rst=0, any time, asynchronous):
  - state=IDLE; busy=0, done=0, product=0; A, Q, q_1 and counter cleared.
  - An operation in flight is aborted with no done pulse.
  - First start is accepted on the first rising edge after rst returns high.
- Latency: start sampled at edge T gives busy=1 from T to T+ITER. DONE is entered at edge T+ITER, so done=1 in the following cycle.
  - done high = ITER+1 cycles after the start edge.
  - WIDTH=6: radix-2 ITER=7 (done at cycle 8); radix-4 ITER=4 (done at cycle 5).
- busy and done are never high together.
- product changes only at the DONE entry edge and otherwise holds.
- start while busy=1 is ignored; no queuing.
- start during the done cycle is accepted (back-to-back). busy rises the next cycle; the old product holds until the new done.

## Test plan
- WIDTH=6, RADIX4=0, tc=1, a=-32, b=-32 -> product=0x400 (1024); done exactly 8 cycles after the start edge; busy high 7 cycles.
- WIDTH=6, RADIX4=1, tc=1, a=31, b=-32 -> product=0xC20 (-992); done at cycle 5.
- WIDTH=6, both radices, tc=0, a=63, b=63 -> product=0xF81 (3969); tc=0, a=0, b=63 -> 0x000.
- Hold start high through two ops (a=5,b=-3 then a=-1,b=-1, tc=1):
  - done pulses twice, results 0xFF1 then 0x001.
  - A start pulse mid-RUN is ignored and operand changes mid-RUN do not corrupt results.
- Assert rst=0 at iteration 3 of an operation -> busy, done and product are 0 immediately (asynchronously), with no done pulse; a fresh op after release is correct.
- Random sweep with WIDTH in {4,6,8,16}, both radices and both tc values, ≥1000 ops each:
  - product matches the reference multiply modulo 2^(2*WIDTH).
  - Every op has latency ITER+1.
